tagged_regfile_ckpt: RTL and testbench
======================================

Name: tagged_regfile_ckpt

Overview:
Parametrised renamed architectural register file for the Tomasulo core. Each entry holds a value and a pending reservation-station tag (0 = ready). Successor features:
- multiple CDB write-back ports;
- N read ports with same-cycle CDB bypass;
- an internal bank of tag checkpoints for branch speculation, with allocate/free/restore and CDB wake-up applied to stored checkpoints.

Sits between decode/issue and the reservation stations; the ROB/branch unit drives the checkpoint ports.

Parameters:
NUM_REGS, 32, architectural registers; x0 hardwired zero.
XLEN, 32, data width.
TAG_W, `NUM_SRBITS, tag width; tag 0 = no pending producer.
NUM_RD, 2, read ports.
NUM_CDB, 2, CDB broadcast ports.
NUM_CKPT, 4, checkpoint slots (power of 2); CK_W = clog2(NUM_CKPT).

Ports:
clk  in  1  clock
rst_n  in  1  reset (see Behaviour)
rd_addr  in  NUM_RD*5  read addresses
rd_data  out  NUM_RD x tagged_data_t  value+tag per port
ren_we  in  1  rename: set tag of ren_addr
ren_addr  in  5  rename destination
ren_tag  in  TAG_W  new tag (nonzero)
jal_we  in  1  direct write of jal_pc+4, tag cleared
jal_addr  in  5  jump link register
jal_pc  in  XLEN  jump PC
cdb_i  in  NUM_CDB x cdb_bus_t  valid/tag/data per port
ck_save  in  1  request checkpoint of tag table
ck_save_ok  out  1  save accepted this cycle
ck_save_id  out  CK_W  slot allocated (valid with ck_save_ok)
ck_full  out  1  no free slot
ck_free  in  1  release slot (branch resolved correct)
ck_free_id  in  CK_W  slot to release
ck_restore  in  1  mispredict: restore tags from slot
ck_restore_id  in  CK_W  slot to restore
ck_kill_mask  in  NUM_CKPT  slots freed on restore (younger branches)
debug_addr  in  5  debug select
debug_data  out  TAG_W+XLEN  {tag,value}; 0 for x0

Behaviour:
- Reset: asynchronous assert, synchronous deassert, active-low. Clears all values, tags, checkpoint contents and slot-valid bits. Outputs after reset: rd_data={0,0} for any address, ck_full=0, ck_save_ok=0, ck_save_id=0, debug_data=0.
- Reading: combinational.
  - x0 returns {0,0}.
  - If the entry's tag is nonzero and matches a valid CDB port this cycle, return tag 0 and that port's data.
  - Otherwise return stored {tag,value}.
- CDB match for entry i, port p: cdb_i[p].valid && tag[i]!=0 && cdb_i[p].tag==tag[i]. Duplicate valid tags across ports are illegal; lowest p wins for data.
- Per-register next-state priority:
  - Tag: ren_we match > jal_we match > CDB match (clear).
  - Value: jal_we match writes jal_pc+4 (mod 2^XLEN); else CDB match writes data. CDB value is written even when the same cycle's rename overwrites the tag.
  - Writes to x0 are ignored.
- Checkpoint save:
  - Slot = lowest index with valid=0, combinationally, so ck_save_id is valid the same cycle.
  - Snapshot = the full post-update tag table of this cycle, including same-cycle rename and CDB clears.
  - When full: ck_save_ok=0 and nothing changes.
  - ck_full = all valid bits set (registered state, not including same-cycle free).
- Stored checkpoints: every valid slot clears any entry matching a valid CDB port each cycle. A restored table therefore never waits on an already-broadcast tag.
- Free: clears the valid bit of ck_free_id. A slot freed this cycle is not reusable by a save in the same cycle. Freeing an invalid slot is a no-op.
- Restore:
  - The live tag table loads slot ck_restore_id with same-cycle CDB clears applied.
  - Values are untouched.
  - ren_we, jal_we and ck_save are ignored that cycle (ck_save_ok=0).
  - The restored slot and all slots in ck_kill_mask are freed.
  - If ck_restore and ck_free occur together, both frees apply.
  - Restoring an invalid slot is illegal (assertion).
- The FSM per slot is FREE -> VALID (save) -> FREE (free/restore/kill).

Decomposition:
- Package: tagged_data_t, cdb_bus_t, `NUM_SRBITS, ck_id_t.
- Sub-module tag_ckpt_bank: slot storage, valid bits, priority allocator, CDB clear of stored tags. The parent holds values, live tags, bypass and debug.

Test Plan:
1. Reset mid-operation (rst_n low while ren_we=1) -> all rd_data={0,0}, ck_full=0, next cycle unaffected by stale rename.
2. ren x5 tag 3, then CDB0 {tag 3, 0xDEAD_BEEF} -> same-cycle read of x5 gives {0,0xDEADBEEF}; next cycle stored tag 0.
3. Same cycle: ren x7 tag 2 plus CDB1 clearing old tag 1 of x7 -> x7 tag=2, value=CDB data.
4. Four saves -> ids 0,1,2,3, ck_full=1; fifth save -> ck_save_ok=0. free id 1 plus save in same cycle -> rejected; next cycle save -> id 1.
5. Save with x3 tag 4; ren x3 tag 6; CDB tag 4 broadcasts; restore that slot with kill_mask=0b1000 -> x3 tag 0 (not 4); restored slot and slot 3 free.
6. jal_we x1, jal_pc=0xFFFF_FFFC, plus ren x1 tag 5 same cycle -> x1 value 0x0000_0000, tag 5; writes to x0 leave debug_data=0.

Source files
------------

// File: rtl/tagged_regfile_ckpt_pkg.sv
// Shared types for the tagged register file and its checkpoint bank.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
`ifndef NUM_SRBITS
`define NUM_SRBITS 4
`endif

package tagged_regfile_ckpt_pkg;

  localparam int XLEN_P     = 32;
  localparam int TAG_W_P    = `NUM_SRBITS;
  localparam int NUM_CKPT_P = 4;
  localparam int CK_W_P     = $clog2(NUM_CKPT_P);

  typedef logic [TAG_W_P-1:0] tag_t;
  typedef logic [CK_W_P-1:0]  ck_id_t;

  // One register-file read result: pending producer tag (0 = ready) and value.
  typedef struct packed {
    tag_t              tag;
    logic [XLEN_P-1:0] value;
  } tagged_data_t;

  // One common-data-bus broadcast port.
  typedef struct packed {
    logic              valid;
    tag_t              tag;
    logic [XLEN_P-1:0] data;
  } cdb_bus_t;

  typedef enum logic {
    SLOT_FREE  = 1'b0,
    SLOT_VALID = 1'b1
  } slot_st_e;

  // A tag of 0 means "no producer", so it never matches a broadcast.
  function automatic logic cdb_hit(input cdb_bus_t c, input tag_t t);
    return c.valid && (t != '0) && (c.tag == t);
  endfunction

endpackage

// File: rtl/tag_ckpt_bank.sv
// Checkpoint bank: NUM_CKPT snapshots of the tag table with valid state, lowest-free allocator, CDB wake-up.
// Latency: allocation id / restore view are combinational; stored state updates on the next clk edge.
// Backpressure: save is refused (save_ok=0) while every slot is valid; frees take effect next cycle.
//
// Ports: cdb_i (wake-up), snap_tags (table to store on save), save_req/save_ok/save_id/full,
//        free/free_id, restore/restore_id/kill_mask, restore_tags (selected slot with CDB clears applied).
module tag_ckpt_bank
  import tagged_regfile_ckpt_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_CDB  = 2,
  parameter int NUM_CKPT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  cdb_bus_t [NUM_CDB-1:0]      cdb_i,
  input  tag_t     [NUM_REGS-1:0]     snap_tags,
  input  logic                        save_req,
  output logic                        save_ok,
  output logic [$clog2(NUM_CKPT)-1:0] save_id,
  output logic                        full,
  input  logic                        free,
  input  logic [$clog2(NUM_CKPT)-1:0] free_id,
  input  logic                        restore,
  input  logic [$clog2(NUM_CKPT)-1:0] restore_id,
  input  logic [NUM_CKPT-1:0]         kill_mask,
  output tag_t     [NUM_REGS-1:0]     restore_tags
);

  localparam int CK_W = $clog2(NUM_CKPT);

  slot_st_e slot_st     [NUM_CKPT];
  slot_st_e slot_st_nxt [NUM_CKPT];
  tag_t     slot_tags   [NUM_CKPT][NUM_REGS];

  logic [NUM_CKPT-1:0][NUM_REGS-1:0] slot_hit;
  logic                              free_found;
  logic [CK_W-1:0]                   alloc_id;

  // Lowest free slot wins; scanning downward leaves the lowest index last.
  always_comb begin
    free_found = 1'b0;
    alloc_id   = '0;
    for (int s = NUM_CKPT - 1; s >= 0; s--) begin
      if (slot_st[s] == SLOT_FREE) begin
        free_found = 1'b1;
        alloc_id   = CK_W'(s);
      end
    end
  end

  // Allocation looks only at registered state, so a slot freed this cycle
  // still reads as valid and cannot be handed out again until next cycle.
  assign full    = !free_found;
  assign save_ok = save_req && free_found;
  assign save_id = alloc_id;

  always_comb begin
    for (int s = 0; s < NUM_CKPT; s++) begin
      slot_st_nxt[s] = slot_st[s];
    end
    for (int s = 0; s < NUM_CKPT; s++) begin
      if ((free && (free_id == CK_W'(s))) ||
          (restore && ((restore_id == CK_W'(s)) || kill_mask[s]))) begin
        slot_st_nxt[s] = SLOT_FREE;
      end else if (save_ok && (alloc_id == CK_W'(s))) begin
        slot_st_nxt[s] = SLOT_VALID;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_CKPT; s++) begin
        slot_st[s] <= SLOT_FREE;
      end
    end else begin
      for (int s = 0; s < NUM_CKPT; s++) begin
        slot_st[s] <= slot_st_nxt[s];
      end
    end
  end

  always_comb begin
    slot_hit = '0;
    for (int s = 0; s < NUM_CKPT; s++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int p = 0; p < NUM_CDB; p++) begin
          if (cdb_hit(cdb_i[p], slot_tags[s][i])) begin
            slot_hit[s][i] = 1'b1;
          end
        end
      end
    end
  end

  // Stored snapshots keep waking up so a restore never re-waits on a tag
  // that was already broadcast while the branch was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_CKPT; s++) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          slot_tags[s][i] <= '0;
        end
      end
    end else begin
      for (int s = 0; s < NUM_CKPT; s++) begin
        if (save_ok && (alloc_id == CK_W'(s))) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            slot_tags[s][i] <= snap_tags[i];
          end
        end else if (slot_st[s] == SLOT_VALID) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (slot_hit[s][i]) begin
              slot_tags[s][i] <= '0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      restore_tags[i] = slot_hit[restore_id][i] ? '0 : slot_tags[restore_id][i];
    end
  end

  a_restore_valid_slot: assert property (
    @(posedge clk) disable iff (!rst_n) restore |-> (slot_st[restore_id] == SLOT_VALID)
  );

endmodule

// File: rtl/tagged_regfile_ckpt.sv
// Renamed architectural register file: value + pending tag per entry, CDB write-back/bypass, tag checkpoints.
// Latency: reads and checkpoint allocation are combinational; writes, renames and restores land on the next clk edge.
// Backpressure: none on reads/writes; ck_save is refused (ck_save_ok=0) when all slots are valid or during a restore.
//
// Ports: rd_addr/rd_data (NUM_RD bypassed read ports), ren_* (rename), jal_* (link write),
//        cdb_i (write-back), ck_* (checkpoint save/free/restore), debug_addr/debug_data (raw {tag,value}).
// rst_n is expected to come from an upstream synchroniser: asserts asynchronously, releases on clk.
module tagged_regfile_ckpt
  import tagged_regfile_ckpt_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = XLEN_P,
  parameter int TAG_W    = TAG_W_P,
  parameter int NUM_RD   = 2,
  parameter int NUM_CDB  = 2,
  parameter int NUM_CKPT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_RD*5-1:0]         rd_addr,
  output tagged_data_t [NUM_RD-1:0]   rd_data,
  input  logic                        ren_we,
  input  logic [4:0]                  ren_addr,
  input  logic [TAG_W-1:0]            ren_tag,
  input  logic                        jal_we,
  input  logic [4:0]                  jal_addr,
  input  logic [XLEN-1:0]             jal_pc,
  input  cdb_bus_t [NUM_CDB-1:0]      cdb_i,
  input  logic                        ck_save,
  output logic                        ck_save_ok,
  output logic [$clog2(NUM_CKPT)-1:0] ck_save_id,
  output logic                        ck_full,
  input  logic                        ck_free,
  input  logic [$clog2(NUM_CKPT)-1:0] ck_free_id,
  input  logic                        ck_restore,
  input  logic [$clog2(NUM_CKPT)-1:0] ck_restore_id,
  input  logic [NUM_CKPT-1:0]         ck_kill_mask,
  input  logic [4:0]                  debug_addr,
  output logic [TAG_W+XLEN-1:0]       debug_data
);

  tag_t              tags [NUM_REGS];
  logic [XLEN-1:0]   vals [NUM_REGS];
  tag_t [NUM_REGS-1:0] tag_nxt;
  logic [XLEN-1:0]   val_nxt [NUM_REGS];
  tag_t [NUM_REGS-1:0] restore_tags;

  logic            ren_en;
  logic            jal_en;
  logic            save_req;
  logic [XLEN-1:0] jal_val;

  // A restore rewinds the rename map, so any same-cycle rename/link/save
  // belongs to the squashed path and is dropped.
  assign ren_en   = ren_we && !ck_restore;
  assign jal_en   = jal_we && !ck_restore;
  assign save_req = ck_save && !ck_restore;
  assign jal_val  = jal_pc + XLEN'(4);

  // Tag priority: rename > link write > CDB clear; restore overrides all.
  // Values follow the live tag even when a rename replaces it this cycle.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      tag_nxt[i] = tags[i];
      val_nxt[i] = vals[i];
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
        if (cdb_hit(cdb_i[p], tags[i])) begin
          tag_nxt[i] = '0;
          val_nxt[i] = cdb_i[p].data;
        end
      end
      if (jal_en && (jal_addr == 5'(i))) begin
        tag_nxt[i] = '0;
        val_nxt[i] = jal_val;
      end
      if (ren_en && (ren_addr == 5'(i))) begin
        tag_nxt[i] = tag_t'(ren_tag);
      end
      if (ck_restore) begin
        tag_nxt[i] = restore_tags[i];
      end
      if (i == 0) begin
        tag_nxt[i] = '0;
        val_nxt[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tags[i] <= '0;
        vals[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tags[i] <= tag_nxt[i];
        vals[i] <= val_nxt[i];
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [4:0]   a;
    tagged_data_t byp;

    assign a = rd_addr[r*5 +: 5];

    // Same-cycle bypass: a consumer reading during the broadcast sees the
    // result as ready; lowest CDB port wins if tags were ever duplicated.
    always_comb begin
      byp.tag   = tags[a];
      byp.value = vals[a];
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
        if (cdb_hit(cdb_i[p], tags[a])) begin
          byp.tag   = '0;
          byp.value = cdb_i[p].data;
        end
      end
    end

    assign rd_data[r] = (a == 5'd0) ? '0 : byp;
  end

  assign debug_data = (debug_addr == 5'd0) ? '0 : {tags[debug_addr], vals[debug_addr]};

  tag_ckpt_bank #(
    .NUM_REGS (NUM_REGS),
    .NUM_CDB  (NUM_CDB),
    .NUM_CKPT (NUM_CKPT)
  ) u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .cdb_i        (cdb_i),
    .snap_tags    (tag_nxt),
    .save_req     (save_req),
    .save_ok      (ck_save_ok),
    .save_id      (ck_save_id),
    .full         (ck_full),
    .free         (ck_free),
    .free_id      (ck_free_id),
    .restore      (ck_restore),
    .restore_id   (ck_restore_id),
    .kill_mask    (ck_kill_mask),
    .restore_tags (restore_tags)
  );

endmodule

// File: tb/tb_tagged_regfile_ckpt.sv
// Directed bench for tagged_regfile_ckpt: reset, rename/CDB, bypass, checkpoint save/free/restore, link writes.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled mid-cycle.
// Backpressure: exercises checkpoint refusal when full and during same-cycle free.
module tb_tagged_regfile_ckpt;
  import tagged_regfile_ckpt_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [9:0]            rd_addr;
  tagged_data_t [1:0]    rd_data;
  logic                  ren_we;
  logic [4:0]            ren_addr;
  logic [TAG_W_P-1:0]    ren_tag;
  logic                  jal_we;
  logic [4:0]            jal_addr;
  logic [31:0]           jal_pc;
  cdb_bus_t [1:0]        cdb;
  logic                  ck_save;
  logic                  ck_save_ok;
  ck_id_t                ck_save_id;
  logic                  ck_full;
  logic                  ck_free;
  ck_id_t                ck_free_id;
  logic                  ck_restore;
  ck_id_t                ck_restore_id;
  logic [3:0]            ck_kill_mask;
  logic [4:0]            debug_addr;
  logic [TAG_W_P+31:0]   debug_data;

  int checks = 0;
  int passed = 0;

  tagged_regfile_ckpt dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .ren_we        (ren_we),
    .ren_addr      (ren_addr),
    .ren_tag       (ren_tag),
    .jal_we        (jal_we),
    .jal_addr      (jal_addr),
    .jal_pc        (jal_pc),
    .cdb_i         (cdb),
    .ck_save       (ck_save),
    .ck_save_ok    (ck_save_ok),
    .ck_save_id    (ck_save_id),
    .ck_full       (ck_full),
    .ck_free       (ck_free),
    .ck_free_id    (ck_free_id),
    .ck_restore    (ck_restore),
    .ck_restore_id (ck_restore_id),
    .ck_kill_mask  (ck_kill_mask),
    .debug_addr    (debug_addr),
    .debug_data    (debug_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] tv(input int t, input logic [31:0] v);
    tag_t tt;
    tt = tag_t'(t);
    return 64'({tt, v});
  endfunction

  task automatic dbg(input string tag, input logic [4:0] a, input int t, input logic [31:0] v);
    debug_addr = a;
    #1;
    chk(tag, 64'(debug_data), tv(t, v));
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr = {5'd0, 5'd5};
    ren_we = 1'b1; ren_addr = 5'd5; ren_tag = 4'd3;
    jal_we = 1'b0; jal_addr = '0; jal_pc = '0;
    cdb = '0;
    ck_save = 1'b0; ck_free = 1'b0; ck_free_id = '0;
    ck_restore = 1'b0; ck_restore_id = '0; ck_kill_mask = '0;
    debug_addr = 5'd5;

    // Reset held while a rename is presented.
    tick(); tick();
    chk("rst_rd0",     64'(rd_data[0]), 64'd0);
    chk("rst_rd1_x0",  64'(rd_data[1]), 64'd0);
    chk("rst_full",    64'(ck_full), 64'd0);
    chk("rst_save_ok", 64'(ck_save_ok), 64'd0);
    chk("rst_save_id", 64'(ck_save_id), 64'd0);
    chk("rst_debug",   64'(debug_data), 64'd0);
    ren_we = 1'b0;
    rst_n = 1'b1;
    tick();
    dbg("post_rst_x5", 5'd5, 0, 32'h0);

    // Rename x5 -> tag 3, then broadcast tag 3 with a same-cycle read.
    ren_we = 1'b1; ren_addr = 5'd5; ren_tag = 4'd3;
    tick();
    ren_we = 1'b0;
    dbg("ren_x5", 5'd5, 3, 32'h0);
    cdb[0].valid = 1'b1; cdb[0].tag = 4'd3; cdb[0].data = 32'hDEAD_BEEF;
    #1;
    chk("bypass_x5", 64'(rd_data[0]), tv(0, 32'hDEAD_BEEF));
    chk("bypass_x0", 64'(rd_data[1]), 64'd0);
    tick();
    cdb[0] = '0;
    dbg("wb_x5", 5'd5, 0, 32'hDEAD_BEEF);

    // Rename x7 while its previous producer broadcasts on CDB1.
    ren_we = 1'b1; ren_addr = 5'd7; ren_tag = 4'd1;
    tick();
    ren_tag = 4'd2;
    cdb[1].valid = 1'b1; cdb[1].tag = 4'd1; cdb[1].data = 32'h1234_5678;
    tick();
    ren_we = 1'b0; cdb[1] = '0;
    dbg("ren_cdb_x7", 5'd7, 2, 32'h1234_5678);

    // Fill all checkpoint slots.
    ck_save = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("save_ok", 64'(ck_save_ok), 64'd1);
      chk("save_id", 64'(ck_save_id), 64'(k));
      tick();
    end
    #1;
    chk("full_set",    64'(ck_full), 64'd1);
    chk("full_reject", 64'(ck_save_ok), 64'd0);
    ck_free = 1'b1; ck_free_id = 2'd1;
    #1;
    chk("free_same_cycle_reject", 64'(ck_save_ok), 64'd0);
    tick();
    ck_free = 1'b0;
    #1;
    chk("after_free_full", 64'(ck_full), 64'd0);
    chk("reuse_ok",        64'(ck_save_ok), 64'd1);
    chk("reuse_id",        64'(ck_save_id), 64'd1);
    tick();
    ck_save = 1'b0;
    #1;
    chk("refull", 64'(ck_full), 64'd1);
    for (int k = 0; k < 4; k++) begin
      ck_free = 1'b1; ck_free_id = ck_id_t'(k);
      tick();
    end
    ck_free = 1'b0;
    #1;
    chk("all_freed", 64'(ck_full), 64'd0);

    // Snapshot x3=4 (same-cycle rename), rename x3 to 6, broadcast 4, restore.
    ren_we = 1'b1; ren_addr = 5'd3; ren_tag = 4'd4;
    ck_save = 1'b1;
    #1;
    chk("spec_save_id0", 64'(ck_save_id), 64'd0);
    tick();
    ren_tag = 4'd6;
    #1;
    chk("spec_save_id1", 64'(ck_save_id), 64'd1);
    tick();
    ren_we = 1'b0;
    tick();
    #1;
    chk("spec_save_id3", 64'(ck_save_id), 64'd3);
    tick();
    ck_save = 1'b0;
    cdb[0].valid = 1'b1; cdb[0].tag = 4'd4; cdb[0].data = 32'hAAAA_0004;
    tick();
    cdb[0] = '0;
    dbg("live_x3_tag6", 5'd3, 6, 32'h0);
    ck_restore = 1'b1; ck_restore_id = 2'd0; ck_kill_mask = 4'b1000;
    ren_we = 1'b1; ren_addr = 5'd9; ren_tag = 4'd7;
    tick();
    ck_restore = 1'b0; ck_kill_mask = '0; ren_we = 1'b0;
    dbg("restore_x3", 5'd3, 0, 32'h0);
    dbg("restore_x7", 5'd7, 2, 32'h1234_5678);
    dbg("restore_ren_ignored", 5'd9, 0, 32'h0);
    ck_save = 1'b1;
    #1;
    chk("restored_slot_free", 64'(ck_save_id), 64'd0);
    tick();
    #1;
    chk("killed_slot_free_ok", 64'(ck_save_ok), 64'd1);
    chk("killed_slot_free_id", 64'(ck_save_id), 64'd3);
    tick();
    ck_save = 1'b0;
    #1;
    chk("full_after_refill", 64'(ck_full), 64'd1);

    // Link write wrapping to zero alongside a rename of the same register.
    jal_we = 1'b1; jal_addr = 5'd1; jal_pc = 32'hFFFF_FFFC;
    ren_we = 1'b1; ren_addr = 5'd1; ren_tag = 4'd5;
    tick();
    ren_we = 1'b0;
    jal_addr = 5'd2; jal_pc = 32'h0000_0100;
    tick();
    jal_we = 1'b0;
    dbg("jal_ren_x1", 5'd1, 5, 32'h0);
    dbg("jal_x2",     5'd2, 0, 32'h0000_0104);
    rd_addr = {5'd1, 5'd0};
    cdb[1].valid = 1'b1; cdb[1].tag = 4'd5; cdb[1].data = 32'h0000_0055;
    #1;
    chk("bypass_cdb1_x1", 64'(rd_data[1]), tv(0, 32'h55));
    tick();
    cdb[1] = '0;

    // Writes to x0 are dropped.
    jal_we = 1'b1; jal_addr = 5'd0; jal_pc = 32'h10;
    ren_we = 1'b1; ren_addr = 5'd0; ren_tag = 4'd3;
    tick();
    jal_we = 1'b0; ren_we = 1'b0;
    dbg("x0_debug", 5'd0, 0, 32'h0);
    chk("x0_read", 64'(rd_data[0]), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
